// File: rtl/recv_protocol.sv
// Serial frame receiver: hunts for the 011111 start sequence, deserializes a
// DATA_W-bit payload, checks the trailing guard bit and hands words off via valid/ack.
module recv_protocol #(
  parameter int                 DATA_W    = 55,
  parameter int                 SEQ_LEN   = 6,
  parameter logic [SEQ_LEN-1:0] START_SEQ = 6'b011111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_Data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] RX_Data,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    RECV  = 2'b01,
    GUARD = 2'b10
  } state_t;

  state_t              state, state_d;
  logic [SEQ_LEN-1:0]  hsr, hsr_d, hunt_win;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   sr, sr_d;
  logic [DATA_W-1:0]   rx_data_d;
  logic                rx_valid_d, rx_busy_d, frame_err_d, overrun_d;

  assign hunt_win = {hsr[SEQ_LEN-2:0], S_Data};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state;
    hsr_d       = hsr;
    cnt_d       = cnt;
    sr_d        = sr;
    rx_data_d   = RX_Data;
    rx_valid_d  = rx_valid & ~rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state)
      HUNT: begin
        hsr_d = hunt_win;
        if (hunt_win == START_SEQ) begin
          state_d = RECV;
          cnt_d   = CNT_W'(DATA_W);
        end
      end
      RECV: begin
        sr_d  = {sr[DATA_W-2:0], S_Data};
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = GUARD;
      end
      GUARD: begin
        if (!S_Data) begin
          rx_data_d  = sr;
          rx_valid_d = 1'b1;
          // An ack on the commit edge consumes the old word, so it is not an overrun.
          overrun_d  = rx_valid & ~rx_ack;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = HUNT;
        hsr_d   = '1;
      end
      default: begin
        state_d = HUNT;
        hsr_d   = '1;
      end
    endcase

    rx_busy_d = (state_d == RECV) || (state_d == GUARD);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      hsr       <= '1;
      cnt       <= '0;
      RX_Data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      hsr       <= hsr_d;
      cnt       <= cnt_d;
      RX_Data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      rx_busy   <= rx_busy_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

  // NOTE: the payload shift register is fully overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    sr <= sr_d;
  end

endmodule

// File: tb/tb_recv_protocol.sv
// Directed self-checking bench for recv_protocol: latency, in-payload patterns,
// stuck-at-1 line, guard errors, overrun/ack interaction and mid-frame reset.
module tb_recv_protocol;

  localparam int DATA_W = 55;

  logic              clk = 1'b0;
  logic              rst;
  logic              S_Data;
  logic              rx_ack;
  logic [DATA_W-1:0] RX_Data;
  logic              rx_valid, rx_busy, frame_err, overrun;

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt = 0, valid_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;

  recv_protocol dut (
    .clk       (clk),
    .rst       (rst),
    .S_Data    (S_Data),
    .rx_ack    (rx_ack),
    .RX_Data   (RX_Data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Cycle-level event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_busy)   busy_cnt++;
    if (rx_valid)  valid_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    S_Data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    logic [5:0] seq;
    seq = 6'b011111;
    for (int i = 5; i >= 0; i--) send_bit(seq[i]);
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] p, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(p[i]);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] p, input logic guard, input logic ack_on_guard);
    logic ack_save;
    send_start();
    send_bits(p, DATA_W - 1, 0);
    ack_save = rx_ack;
    if (ack_on_guard) rx_ack = 1'b1;
    send_bit(guard);
    rx_ack = ack_save;
    S_Data = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " RX_Data"},   64'(RX_Data), 64'h0);
    check({tag, " rx_valid"},  64'(rx_valid), 64'h0);
    check({tag, " rx_busy"},   64'(rx_busy), 64'h0);
    check({tag, " frame_err"}, 64'(frame_err), 64'h0);
    check({tag, " overrun"},   64'(overrun), 64'h0);
  endtask

  initial begin
    int b0, v0, f0, o0;
    logic [DATA_W-1:0] p;

    // Reset state
    rst = 1'b1; S_Data = 1'b0; rx_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) send_bit(1'b0);

    // Test 1: basic frame, latency and busy duration
    p = 55'h2A_AAAA_AAAA_AAAA;
    b0 = busy_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_start();
    send_bits(p, DATA_W - 1, 0);
    check("t1 valid before guard", 64'(rx_valid), 64'h0);
    check("t1 busy before guard", 64'(rx_busy), 64'h1);
    send_bit(1'b0);
    check("t1 valid at edge 62", 64'(rx_valid), 64'h1);
    check("t1 data", 64'(RX_Data), 64'(p));
    check("t1 busy dropped", 64'(rx_busy), 64'h0);
    check("t1 busy cycles", 64'(busy_cnt - b0), 64'd56);
    check("t1 no frame_err", 64'(ferr_cnt - f0), 64'h0);
    check("t1 no overrun", 64'(ovr_cnt - o0), 64'h0);
    rx_ack = 1'b1;
    send_bit(1'b0);
    check("t1 ack clears valid", 64'(rx_valid), 64'h0);
    send_bit(1'b0);
    check("t1 ack while idle", 64'(rx_valid), 64'h0);

    // Test 2: start pattern inside payload is data; ack held high
    p = 55'h0F_8000_0000_001F;
    v0 = valid_cnt;
    send_frame(p, 1'b0, 1'b0);
    repeat (20) send_bit(1'b0);
    check("t2 one word", 64'(valid_cnt - v0), 64'd1);
    check("t2 data", 64'(RX_Data), 64'(p));

    // Test 3: line stuck at 1 from reset, then a real frame
    S_Data = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v0 = valid_cnt; b0 = busy_cnt;
    repeat (30) send_bit(1'b1);
    check("t3 no busy on ones", 64'(busy_cnt - b0), 64'h0);
    send_bit(1'b0);
    send_frame(55'h1, 1'b0, 1'b0);
    send_bit(1'b0);
    check("t3 one word", 64'(valid_cnt - v0), 64'd1);
    check("t3 data", 64'(RX_Data), 64'h1);

    // Test 4: guard bit error, then a good all-ones frame back-to-back
    f0 = ferr_cnt;
    send_frame(55'h55, 1'b1, 1'b0);
    check("t4 frame_err pulse", 64'(frame_err), 64'h1);
    check("t4 valid stays 0", 64'(rx_valid), 64'h0);
    check("t4 data kept", 64'(RX_Data), 64'h1);
    p = 55'h7F_FFFF_FFFF_FFFF;
    send_frame(p, 1'b0, 1'b0);
    check("t4 frame_err one cycle", 64'(ferr_cnt - f0), 64'd1);
    check("t4 good data", 64'(RX_Data), 64'(p));
    send_bit(1'b0);

    // Test 5: overrun without ack, then commit with ack on the same edge
    rx_ack = 1'b0;
    o0 = ovr_cnt;
    send_frame(55'h123, 1'b0, 1'b0);
    check("t5 first valid", 64'(rx_valid), 64'h1);
    check("t5 first no overrun", 64'(overrun), 64'h0);
    send_frame(55'h456, 1'b0, 1'b0);
    check("t5 overrun pulse", 64'(overrun), 64'h1);
    check("t5 overwritten data", 64'(RX_Data), 64'h456);
    check("t5 valid held", 64'(rx_valid), 64'h1);
    send_bit(1'b0);
    check("t5 overrun one cycle", 64'(ovr_cnt - o0), 64'd1);
    send_frame(55'h789, 1'b0, 1'b1);
    check("t5 ack commit no overrun", 64'(overrun), 64'h0);
    check("t5 ack commit valid", 64'(rx_valid), 64'h1);
    check("t5 ack commit data", 64'(RX_Data), 64'h789);
    rx_ack = 1'b1;
    send_bit(1'b0);
    check("t5 later ack clears", 64'(rx_valid), 64'h0);
    check("t5 total overruns", 64'(ovr_cnt - o0), 64'd1);
    rx_ack = 1'b0;

    // Test 6: reset mid-payload discards the partial frame
    p = 55'h2A_AAAA_AAAA_AAAA;
    send_start();
    send_bits(p, DATA_W - 1, DATA_W - 30);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6 in reset");
    @(posedge clk); #1;
    check_all_zero("t6 held reset");
    rst = 1'b0;
    v0 = valid_cnt;
    send_bits(p, DATA_W - 31, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t6 partial not committed", 64'(valid_cnt - v0), 64'h0);
    send_frame(55'h3C3, 1'b0, 1'b0);
    check("t6 full frame valid", 64'(rx_valid), 64'h1);
    check("t6 full frame data", 64'(RX_Data), 64'h3C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
